// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver FSM states and the bit-period helper.
// Imported by the receive stream top and its FIFO.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        BREAK
    } uart_rx_state_e;

    // Clocks per bit, integer divide.
    function automatic int cpb(input int freq, input int baud);
        return freq / baud;
    endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// Show-ahead synchronous FIFO, occupancy-tracked full/empty.
// Ports: push_i/wdata_i write, pop_i read, rdata_o head, full_o/empty_o/fill_o status.
module uart_sync_fifo
    import uart_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       push_i,
    input  logic [WIDTH-1:0]           wdata_i,
    input  logic                       pop_i,
    output logic [WIDTH-1:0]           rdata_o,
    output logic                       full_o,
    output logic                       empty_o,
    output logic [$clog2(DEPTH+1)-1:0] fill_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int FW = $clog2(DEPTH+1);

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("uart_sync_fifo: DEPTH must be a power of 2 and >= 2");
    end

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wptr_q;
    logic [AW-1:0]    rptr_q;
    logic [FW-1:0]    fill_q;
    logic             do_push;
    logic             do_pop;

    assign empty_o = (fill_q == '0);
    assign full_o  = (fill_q == FW'(DEPTH));
    assign fill_o  = fill_q;
    // A pop at full frees the slot the write lands in this cycle.
    assign do_pop  = pop_i & ~empty_o;
    assign do_push = push_i & (~full_o | do_pop);
    // Forced to zero while empty so reset and drained states read 0.
    assign rdata_o = empty_o ? '0 : mem[rptr_q];

    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem[wptr_q] <= wdata_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wptr_q <= '0;
            rptr_q <= '0;
            fill_q <= '0;
        end else begin
            if (do_push) begin
                wptr_q <= wptr_q + AW'(1);
            end
            if (do_pop) begin
                rptr_q <= rptr_q + AW'(1);
            end
            if (do_push && !do_pop) begin
                fill_q <= fill_q + FW'(1);
            end else if (do_pop && !do_push) begin
                fill_q <= fill_q - FW'(1);
            end
        end
    end

endmodule

// File: rtl/uart_rx_stream.sv
// 8N1 UART receiver feeding a FIFO, presented as a valid/ready byte stream.
// Ports: rx_i serial in; rdata_o/rvalid_o/rready_i stream; fill_o, frame_err_o, overflow_o status.
module uart_rx_stream
    import uart_pkg::*;
#(
    parameter int FREQ  = 50_000_000,
    parameter int BAUD  = 115_200,
    parameter int DEPTH = 16
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       rx_i,
    output logic [7:0]                 rdata_o,
    output logic                       rvalid_o,
    input  logic                       rready_i,
    output logic [$clog2(DEPTH+1)-1:0] fill_o,
    output logic                       frame_err_o,
    output logic                       overflow_o
);

    localparam int CPB = cpb(FREQ, BAUD);
    localparam int CW  = $clog2(CPB);
    localparam logic [CW-1:0] CYC_LAST = CW'(CPB - 1);
    localparam logic [CW-1:0] CYC_MID  = CW'(CPB / 2 - 1);

    if (CPB < 4) begin : g_bad_cpb
        $error("uart_rx_stream: FREQ/BAUD must be >= 4");
    end

    logic           rx_meta_q;
    logic           rx_s;
    uart_rx_state_e state_q, state_d;
    logic [CW-1:0]  cyc_q, cyc_d;
    logic [2:0]     idx_q, idx_d;
    logic [7:0]     shreg_q, shreg_d;
    logic           push;
    logic           ferr;
    logic           pop;
    logic           full;
    logic           empty;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rx_meta_q <= 1'b1;
            rx_s      <= 1'b1;
        end else begin
            rx_meta_q <= rx_i;
            rx_s      <= rx_meta_q;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            cyc_q       <= '0;
            idx_q       <= '0;
            shreg_q     <= '0;
            frame_err_o <= 1'b0;
            overflow_o  <= 1'b0;
        end else begin
            state_q     <= state_d;
            cyc_q       <= cyc_d;
            idx_q       <= idx_d;
            shreg_q     <= shreg_d;
            frame_err_o <= ferr;
            overflow_o  <= push & full & ~pop;
        end
    end

    always_comb begin
        state_d = state_q;
        cyc_d   = cyc_q;
        idx_d   = idx_q;
        shreg_d = shreg_q;
        push    = 1'b0;
        ferr    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (!rx_s) begin
                    state_d = START;
                    cyc_d   = '0;
                end
            end
            START: begin
                if (cyc_q == CYC_MID) begin
                    if (rx_s) begin
                        state_d = IDLE;
                    end else begin
                        state_d = DATA;
                        cyc_d   = '0;
                        idx_d   = '0;
                    end
                end else begin
                    cyc_d = cyc_q + CW'(1);
                end
            end
            DATA: begin
                if (cyc_q == CYC_LAST) begin
                    shreg_d[idx_q] = rx_s;
                    cyc_d          = '0;
                    if (idx_q == 3'd7) begin
                        state_d = STOP;
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end else begin
                    cyc_d = cyc_q + CW'(1);
                end
            end
            STOP: begin
                // Leaves mid stop bit so a following start edge is seen from IDLE.
                if (cyc_q == CYC_LAST) begin
                    if (rx_s) begin
                        push    = 1'b1;
                        state_d = IDLE;
                    end else begin
                        ferr    = 1'b1;
                        state_d = BREAK;
                    end
                end else begin
                    cyc_d = cyc_q + CW'(1);
                end
            end
            BREAK: begin
                if (rx_s) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign rvalid_o = ~empty;
    assign pop      = rvalid_o & rready_i;

    uart_sync_fifo #(
        .WIDTH (8),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (push),
        .wdata_i (shreg_q),
        .pop_i   (pop),
        .rdata_o (rdata_o),
        .full_o  (full),
        .empty_o (empty),
        .fill_o  (fill_o)
    );

endmodule

// File: tb/tb_uart_rx_stream.sv
// Scoreboard bench for uart_rx_stream at CPB=10, DEPTH=4.
// Frames are driven serially; a monitor checks every accepted byte.
module tb_uart_rx_stream;

    localparam int FREQ  = 1000;
    localparam int BAUD  = 100;
    localparam int CPB   = FREQ / BAUD;
    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       rst_i = 1'b1;
    logic       rx_i = 1'b1;
    logic       rready_i = 1'b0;
    logic [7:0] rdata_o;
    logic       rvalid_o;
    logic [2:0] fill_o;
    logic       frame_err_o;
    logic       overflow_o;

    int         total = 0;
    int         bad = 0;
    int         beats = 0;
    int         ferr_cnt = 0;
    int         ovf_cnt = 0;
    int         exp_ferr = 0;
    int         exp_ovf = 0;
    logic [7:0] exp_q[$];
    bit         rnd_done;

    uart_rx_stream #(
        .FREQ  (FREQ),
        .BAUD  (BAUD),
        .DEPTH (DEPTH)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst_i),
        .rx_i        (rx_i),
        .rdata_o     (rdata_o),
        .rvalid_o    (rvalid_o),
        .rready_i    (rready_i),
        .fill_o      (fill_o),
        .frame_err_o (frame_err_o),
        .overflow_o  (overflow_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: compares every handshake against the scoreboard queue.
    always @(negedge clk) begin
        if (!rst_i) begin
            if (rvalid_o && rready_i) begin
                beats++;
                if (exp_q.size() == 0) begin
                    chk("unexpected_beat", int'(rdata_o), -1);
                end else begin
                    chk("rdata", int'(rdata_o), int'(exp_q.pop_front()));
                end
            end
            if (frame_err_o) ferr_cnt++;
            if (overflow_o) ovf_cnt++;
        end
    end

    task automatic gap(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Called aligned at posedge+1; returns aligned at posedge+1.
    task automatic send_frame(input logic [7:0] b, input logic stop,
                              input bit discard, input bit pop_at_stop);
        logic [9:0] bits;
        bits = {stop, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            if (i == 9 && !discard) begin
                if (!stop) begin
                    exp_ferr++;
                end else if (exp_q.size() < DEPTH || pop_at_stop) begin
                    exp_q.push_back(b);
                end else begin
                    exp_ovf++;
                end
            end
            rx_i = bits[i];
            gap(CPB);
        end
    endtask

    task automatic drain(input string name);
        rready_i = 1'b1;
        for (int i = 0; i < 400 && exp_q.size() != 0; i++) begin
            @(posedge clk);
        end
        gap(2);
        chk({name, "_drained"}, exp_q.size(), 0);
        @(negedge clk);
        chk({name, "_fill0"}, int'(fill_o), 0);
        #1;
        gap(1);
    endtask

    initial begin
        #300000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        int b0;
        // Reset state
        rst_i = 1'b1;
        gap(3);
        rst_i = 1'b0;
        @(negedge clk);
        chk("rst_rvalid", int'(rvalid_o), 0);
        chk("rst_fill", int'(fill_o), 0);
        chk("rst_rdata", int'(rdata_o), 0);
        chk("rst_ferr", int'(frame_err_o), 0);
        chk("rst_ovf", int'(overflow_o), 0);
        gap(5);

        // 1: single frame 0x55
        rready_i = 1'b1;
        b0 = beats;
        send_frame(8'h55, 1'b1, 1'b0, 1'b0);
        gap(10);
        chk("t1_beats", beats - b0, 1);
        chk("t1_ferr", ferr_cnt, exp_ferr);
        chk("t1_ovf", ovf_cnt, exp_ovf);

        // 2: short glitch is rejected
        b0 = beats;
        rx_i = 1'b0;
        gap(3);
        rx_i = 1'b1;
        gap(30);
        chk("t2_beats", beats - b0, 0);
        chk("t2_ferr", ferr_cnt, exp_ferr);

        // 3: bad stop bit then line held low
        send_frame(8'hA3, 1'b0, 1'b0, 1'b0);
        gap(50);
        chk("t3_ferr", ferr_cnt, exp_ferr);
        chk("t3_ferr_one", exp_ferr, 1);
        chk("t3_fill", int'(fill_o), 0);
        rx_i = 1'b1;
        gap(20);
        b0 = beats;
        send_frame(8'h3C, 1'b1, 1'b0, 1'b0);
        gap(10);
        chk("t3_beats", beats - b0, 1);
        chk("t3_ferr_after", ferr_cnt, exp_ferr);

        // 4: overflow with consumer stalled
        rready_i = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            send_frame(8'(i), 1'b1, 1'b0, 1'b0);
        end
        gap(5);
        chk("t4_fill", int'(fill_o), 4);
        chk("t4_ovf", ovf_cnt, exp_ovf);
        chk("t4_ovf_one", exp_ovf, 1);
        drain("t4");

        // 5: reset mid-frame with bytes queued
        rready_i = 1'b0;
        send_frame(8'h11, 1'b1, 1'b0, 1'b0);
        send_frame(8'h22, 1'b1, 1'b0, 1'b0);
        chk("t5_fill_pre", int'(fill_o), 2);
        fork
            send_frame(8'hF0, 1'b1, 1'b1, 1'b0);
            begin
                gap(53);
                rst_i = 1'b1;
                gap(1);
                rst_i = 1'b0;
                exp_q.delete();
                @(negedge clk);
                chk("t5_fill_rst", int'(fill_o), 0);
                chk("t5_rvalid_rst", int'(rvalid_o), 0);
            end
        join
        gap(10);
        rready_i = 1'b1;
        b0 = beats;
        send_frame(8'hC3, 1'b1, 1'b0, 1'b0);
        gap(10);
        chk("t5_beats", beats - b0, 1);

        // 6: push into full FIFO with a coincident pop
        rready_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            send_frame(8'($urandom_range(0, 255)), 1'b1, 1'b0, 1'b0);
        end
        chk("t6_full", int'(fill_o), 4);
        fork
            send_frame(8'h7E, 1'b1, 1'b0, 1'b1);
            begin
                gap(97);
                rready_i = 1'b1;
                gap(1);
                rready_i = 1'b0;
            end
        join
        gap(5);
        chk("t6_ovf", ovf_cnt, exp_ovf);
        chk("t6_fill", int'(fill_o), 4);
        chk("t6_last", int'(exp_q[exp_q.size()-1]), 'h7E);
        drain("t6");

        // 7: random bytes, gaps and consumer stalls
        rnd_done = 1'b0;
        fork
            begin
                for (int i = 0; i < 8; i++) begin
                    send_frame(8'($urandom_range(0, 255)), 1'b1,
                               1'b0, 1'b0);
                    gap($urandom_range(0, 4));
                end
                rnd_done = 1'b1;
            end
            begin
                while (!rnd_done) begin
                    rready_i = 1'($urandom_range(0, 1));
                    gap(1);
                end
            end
        join
        drain("t7");
        chk("t7_ovf", ovf_cnt, exp_ovf);
        chk("t7_ferr", ferr_cnt, exp_ferr);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
